viterbi_k3_frame_decoder: RTL and testbench
===========================================

# viterbi_k3_frame_decoder

Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (generators 7,5 octal) produced by the UART encoder path. It collects one frame of 8 encoded bytes from the UART receiver and decodes them to 32 data bits. The decoded bits are returned as 4 bytes through the UART transmitter handshake. It sits between `async_receiver` and `async_transmitter` in the decode-direction top level.

## Interface
- `NBITS`, 32, decoded bits per frame; multiple of 8; the frame holds 2*NBITS/8 encoded bytes.
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe; `in_data` is valid; driven by `RxD_data_ready`.
- `in_data`  in  8  encoded byte from `RxD_data`.
- `out_start`  out  1  one-cycle transmit request to `TxD_start`.
- `out_data`  out  8  decoded byte; held stable from `out_start` until the next `out_start`.
- `out_busy`  in  1  transmitter busy, from `TxD_busy`.
- `busy`  out  1  high in every state except COLLECT.
- `overrun`  out  1  one-cycle pulse when `in_valid` arrives outside COLLECT.

## Operation
- Frame format:
  - Encoded byte k carries frame bits [8k+7:8k]; bytes arrive in order k = 0, 1, ….
  - For decoded bit i: frame bit 2i = out0 = b^s1^s2, and frame bit 2i+1 = out1 = b^s2.
  - Here b is the input bit, s1 is the previous input bit, and s2 is the input bit before that.
  - The encoder starts in state 0. The frame has no tail bits.
- State encoding: s = {s1,s2}, 2 bits. Next state = {b,s1}.
- FSM states: COLLECT → ACS → PICK → TRACE → SEND → COLLECT.
- COLLECT:
  - Each `in_valid` writes `in_data` into the frame register at the byte counter, then increments the counter.
  - After byte 2*NBITS/8−1 is written, the FSM goes to ACS.
- ACS, one trellis step per cycle, steps i = 0..NBITS−1:
  - Branch metric = Hamming distance (0..2) between the received pair {bit 2i+1, bit 2i} and the expected {out1,out0}.
  - Next state ns = {b,x} has two predecessors, {x,0} and {x,1}.
  - Candidate metric = PM[pred] + BM. The lower candidate wins.
  - On a tie, the predecessor with s2=0 wins.
  - Survivor bit d[i][ns] = s2 of the winning predecessor. Survivor memory is NBITS x 4 bits.
- Path metrics:
  - 7-bit, unsigned, no normalisation.
  - Initialised at COLLECT→ACS to PM[0]=0 and PM[1..3]=63.
  - Maximum value is 63+2*NBITS, which fits in 7 bits for NBITS=32. Wider NBITS widens the metric to clog2(64+2*NBITS).
- PICK (1 cycle): selects the state with minimum PM. On a tie, the lowest index wins.
- TRACE, steps i = NBITS−1 down to 0, one per cycle:
  - Decoded bit i = s1 of the current state.
  - Predecessor = {s2, d[i][s]}.
- SEND:
  - Decoded byte j = bits [8j+7:8j], sent for j = 0..NBITS/8−1.
  - `out_start` pulses only when `out_busy`=0 and the FSM is not in the cycle immediately after a pulse. This skips one cycle so the transmitter can raise busy.
  - After the last byte's pulse, the FSM returns to COLLECT with the byte counter at 0.
- `in_valid` outside COLLECT: the byte is discarded and `overrun` pulses.
- `in_valid` coincident with the final ACS-entry cycle: counts as outside COLLECT.

## Timing
- Reset values:
  - `out_start`=0, `out_data`=0x00, `busy`=0, `overrun`=0.
  - FSM = COLLECT, byte counter = 0, path metrics = initial values.
  - Survivor and output registers are cleared.
- Reset asserted mid-frame or mid-decode aborts immediately. Partial frames are lost.
- Cycle numbering: call the cycle in which the final byte is sampled cycle 0.
- Latency:
  - ACS occupies cycles 1..NBITS; `busy` rises in cycle 1.
  - PICK occupies cycle NBITS+1.
  - TRACE occupies cycles NBITS+2..2*NBITS+1.
  - The earliest first `out_start` is cycle 2*NBITS+2 (66 for NBITS=32), with `out_busy` low.
- `out_data` is updated in the same cycle `out_start` is driven high.
- `busy` falls in the cycle after the last `out_start`.
- Sustained throughput is limited by the UART; the decode core is idle in COLLECT and SEND.

## Test plan
- All-zero frame:
  - Stimulus: 8 bytes 0x00.
  - Required: out bytes 00 00 00 00. No `overrun`. First `out_start` exactly 66 cycles after the last `in_valid`.
- Single-bit vector (encoding of 0x00000001):
  - Stimulus: 37 00 00 00 00 00 00 00.
  - Required: 01 00 00 00.
- Single channel error:
  - Stimulus: 37 04 00 00 00 00 00 00 (frame bit 10 flipped).
  - Required: 01 00 00 00.
- Random round trip: 200 random 32-bit words through a reference encoder model, with 0 or 1 flipped bits → bit-exact data out.
- Back-pressure and reset:
  - Stimulus: hold `out_busy`=1 for 500 cycles at SEND entry.
  - Required: no `out_start` while busy; exactly 4 pulses total, one per byte.
  - Stimulus: assert `rst` during ACS cycle 10, then send a fresh 37 00 … frame.
  - Required: outputs at reset values, then 01 00 00 00.
- Overrun: extra `in_valid` (0xFF) during TRACE → one-cycle `overrun`; decoded result unchanged; the next frame decodes from byte 0.

Source files
------------

// File: rtl/viterbi_k3_frame_decoder.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) code: collects one
// encoded frame, runs the trellis one step per cycle, traces back, then streams bytes out.
module viterbi_k3_frame_decoder #(
  parameter int NBITS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_start,
  output logic [7:0] out_data,
  input  logic       out_busy,
  output logic       busy,
  output logic       overrun
);
  localparam int NBYTES = 2 * NBITS / 8;
  localparam int NOUT   = NBITS / 8;
  localparam int CW     = $clog2(NBYTES);
  localparam int SW     = $clog2(NBITS);
  localparam int OW     = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int PMW    = $clog2(64 + 2 * NBITS);
  localparam logic [CW-1:0]  LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [SW-1:0]  LAST_STEP = SW'(NBITS - 1);
  localparam logic [OW-1:0]  LAST_OUT  = OW'(NOUT - 1);
  localparam logic [PMW-1:0] PM_FAR    = PMW'(63);

  typedef enum logic [2:0] {COLLECT, ACS, PICK, TRACE, SEND} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*NBITS-1:0] frame;
  logic [PMW-1:0]     pm     [4];
  logic [PMW-1:0]     pm_nxt [4];
  logic [3:0]         sel;
  logic [3:0]         surv   [NBITS];
  logic [SW-1:0]      step;
  logic [1:0]         cur;
  logic [1:0]         best;
  logic [NBITS-1:0]   dec;
  logic [OW-1:0]      oidx;
  logic               gap;
  logic [7:0]         hold;
  logic [1:0]         rx;

  // State s = {s1,s2}; expected pair is {out1,out0} = {b^s2, b^s1^s2}.
  function automatic logic [1:0] branch_metric(input logic [1:0] s, input logic b,
                                               input logic [1:0] r);
    logic [1:0] diff;
    diff = {b ^ s[0], b ^ s[1] ^ s[0]} ^ r;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

  // Returns {survivor bit, new metric}; a tie keeps the s2=0 predecessor.
  function automatic logic [PMW:0] acs_cell(input logic [1:0] ns, input logic [PMW-1:0] m0,
                                            input logic [PMW-1:0] m1, input logic [1:0] r);
    logic [PMW-1:0] c0;
    logic [PMW-1:0] c1;
    c0 = m0 + PMW'(branch_metric({ns[0], 1'b0}, ns[1], r));
    c1 = m1 + PMW'(branch_metric({ns[0], 1'b1}, ns[1], r));
    return (c1 < c0) ? {1'b1, c1} : {1'b0, c0};
  endfunction

  always_comb begin
    rx = frame[{step, 1'b0} +: 2];
    {sel[0], pm_nxt[0]} = acs_cell(2'd0, pm[0], pm[1], rx);
    {sel[1], pm_nxt[1]} = acs_cell(2'd1, pm[2], pm[3], rx);
    {sel[2], pm_nxt[2]} = acs_cell(2'd2, pm[0], pm[1], rx);
    {sel[3], pm_nxt[3]} = acs_cell(2'd3, pm[2], pm[3], rx);
  end

  always_comb begin
    best = 2'd0;
    if (pm[1] < pm[best]) best = 2'd1;
    if (pm[2] < pm[best]) best = 2'd2;
    if (pm[3] < pm[best]) best = 2'd3;
  end

  // The pulse cycle presents the fresh byte; hold keeps it stable until the next pulse.
  assign out_start = (state == SEND) && !out_busy && !gap;
  assign out_data  = out_start ? dec[{oidx, 3'b000} +: 8] : hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      cnt     <= '0;
      frame   <= '0;
      pm[0]   <= '0;
      pm[1]   <= PM_FAR;
      pm[2]   <= PM_FAR;
      pm[3]   <= PM_FAR;
      for (int i = 0; i < NBITS; i++) surv[i] <= '0;
      step    <= '0;
      cur     <= '0;
      dec     <= '0;
      oidx    <= '0;
      gap     <= 1'b0;
      hold    <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= in_valid && (state != COLLECT);
      case (state)
        COLLECT: begin
          if (in_valid) begin
            frame[{cnt, 3'b000} +: 8] <= in_data;
            if (cnt == LAST_BYTE) begin
              cnt   <= '0;
              step  <= '0;
              pm[0] <= '0;
              pm[1] <= PM_FAR;
              pm[2] <= PM_FAR;
              pm[3] <= PM_FAR;
              busy  <= 1'b1;
              state <= ACS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ACS: begin
          for (int n = 0; n < 4; n++) pm[n] <= pm_nxt[n];
          surv[step] <= sel;
          if (step == LAST_STEP) state <= PICK;
          else step <= step + 1'b1;
        end
        PICK: begin
          cur   <= best;
          step  <= LAST_STEP;
          state <= TRACE;
        end
        TRACE: begin
          dec[step] <= cur[1];
          cur       <= {cur[0], surv[step][cur]};
          if (step == '0) begin
            oidx  <= '0;
            gap   <= 1'b0;
            state <= SEND;
          end else begin
            step <= step - 1'b1;
          end
        end
        SEND: begin
          gap <= out_start;
          if (out_start) begin
            hold <= out_data;
            if (oidx == LAST_OUT) begin
              oidx  <= '0;
              busy  <= 1'b0;
              gap   <= 1'b0;
              state <= COLLECT;
            end else begin
              oidx <= oidx + 1'b1;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_k3_frame_decoder.sv
// Bench for viterbi_k3_frame_decoder: directed frames, back-pressure, reset abort,
// overrun, and randomized encode/corrupt/decode round trips.
module tb_viterbi_k3_frame_decoder;
  localparam int NB  = 32;
  localparam int LAT = 2 * NB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_start;
  logic [7:0] out_data;
  logic       out_busy;
  logic       busy;
  logic       overrun;

  int tests  = 0;
  int failed = 0;

  logic [31:0] word_r;
  int          npulse_r, lat_r, novr_r, viol_r;
  logic        busy1_r, busy_end_r, tmo_r;

  viterbi_k3_frame_decoder #(.NBITS(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_start(out_start), .out_data(out_data), .out_busy(out_busy),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: frame bit 2i = b^s1^s2, bit 2i+1 = b^s2, starting from state 0.
  function automatic logic [63:0] encode(input logic [31:0] d);
    logic [63:0] f;
    logic s1, s2, b;
    s1 = 1'b0;
    s2 = 1'b0;
    f  = '0;
    for (int i = 0; i < NB; i++) begin
      b          = d[i];
      f[2*i]     = b ^ s1 ^ s2;
      f[2*i + 1] = b ^ s2;
      s2         = s1;
      s1         = b;
    end
    return f;
  endfunction

  // Leaves the bench at cycle 1 (one cycle after the final byte is sampled).
  task automatic send_frame(input logic [63:0] f);
    for (int k = 0; k < 2 * NB / 8; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = f[8*k +: 8];
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Plays the UART transmitter (busy for txlen cycles after each start), optionally
  // forces busy for `hold` cycles from SEND entry and injects a stray byte at cycle inj.
  task automatic collect(input int hold, input int txlen, input int inj);
    int  cyc, txcnt;
    logic prev;
    cyc = 1; txcnt = 0; prev = 1'b0;
    word_r = '0; npulse_r = 0; lat_r = -1; novr_r = 0; viol_r = 0;
    busy1_r = 1'b0; busy_end_r = 1'b1; tmo_r = 1'b0;
    while (npulse_r < NB / 8) begin
      out_busy = (txcnt > 0) || (cyc >= LAT && cyc < LAT + hold);
      if (txcnt > 0) txcnt--;
      in_valid = (cyc == inj);
      in_data  = (cyc == inj) ? 8'hFF : 8'h00;
      @(negedge clk);
      if (cyc == 1) busy1_r = busy;
      if (overrun) novr_r++;
      if (out_start) begin
        if (out_busy || prev) viol_r++;
        word_r[8*npulse_r +: 8] = out_data;
        if (lat_r < 0) lat_r = cyc;
        npulse_r++;
        txcnt = txlen;
      end
      prev = out_start;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin
        tmo_r = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    out_busy = (txcnt > 0);
    @(negedge clk);
    busy_end_r = busy;
    if (overrun) novr_r++;
    if (out_start) npulse_r++;
    @(posedge clk); #1;
    out_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_start"}, 64'(out_start), 64'd0);
    chk({tag, "_out_data"},  64'(out_data),  64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_overrun"},   64'(overrun),   64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp, input int exp_ovr);
    chk({tag, "_timeout"}, 64'(tmo_r),    64'd0);
    chk({tag, "_word"},    64'(word_r),   64'(exp));
    chk({tag, "_pulses"},  64'(npulse_r), 64'd4);
    chk({tag, "_proto"},   64'(viol_r),   64'd0);
    chk({tag, "_overrun"}, 64'(novr_r),   64'(exp_ovr));
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] f;
    int          pos;
    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_busy = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    send_frame(64'h0);
    collect(0, 3, -1);
    check_frame("zero", 32'h0000_0000, 0);
    chk("zero_latency",  64'(lat_r),      64'(LAT));
    chk("zero_busy_c1",  64'(busy1_r),    64'd1);
    chk("zero_busy_end", 64'(busy_end_r), 64'd0);

    send_frame(64'h0000_0000_0000_0037);
    collect(0, 2, -1);
    check_frame("single_bit", 32'h0000_0001, 0);

    send_frame(64'h0000_0000_0000_0437);
    collect(0, 2, -1);
    check_frame("chan_err", 32'h0000_0001, 0);

    f = encode(32'hA5C3_0F96);
    send_frame(f);
    collect(500, 2, -1);
    check_frame("backpressure", 32'hA5C3_0F96, 0);
    chk("backpressure_latency", 64'(lat_r), 64'(LAT + 500));

    send_frame(64'h0000_0000_0000_0037);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs("mid_acs_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_reset");
    send_frame(64'h0000_0000_0000_0037);
    collect(0, 3, -1);
    check_frame("post_reset", 32'h0000_0001, 0);

    f = encode(32'h1234_5678);
    send_frame(f);
    collect(0, 2, 40);
    check_frame("overrun", 32'h1234_5678, 1);
    f = encode(32'hDEAD_BEEF);
    send_frame(f);
    collect(0, 2, -1);
    check_frame("after_overrun", 32'hDEAD_BEEF, 0);

    // Flips stay out of the final pair: there a flip ties with the path that differs
    // only in the last bit, so exact recovery is only guaranteed for bits 0..61.
    for (int n = 0; n < 200; n++) begin
      d = $urandom;
      f = encode(d);
      if ($urandom_range(0, 1) == 1) begin
        pos = $urandom_range(0, 2 * NB - 3);
        f[pos] = ~f[pos];
      end
      send_frame(f);
      collect(0, $urandom_range(1, 4), -1);
      chk("rand_timeout", 64'(tmo_r),    64'd0);
      chk("rand_word",    64'(word_r),   64'(d));
      chk("rand_pulses",  64'(npulse_r), 64'd4);
      chk("rand_proto",   64'(viol_r),   64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
